// File: rtl/timer_sequencer.sv
// Programmable one-shot / auto-reload timer sequencer around a WIDTH-bit up-counter.
// Start/stop/pause commands, prescaled ticks, one-cycle done pulse on terminal count.
module timer_sequencer #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           cur, nxt;
    logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] term_l, term_nxt;
    logic             mode_l, mode_nxt;
    logic [PRE_W-1:0] prescale_l, prescale_nxt;

    logic tick;
    logic at_term;
    logic load;
    logic count_edge;

    assign tick    = (pre_cnt == prescale_l);
    assign at_term = (q == term_l);
    assign load    = ((cur == IDLE) || (cur == DONE)) && start && !stop;
    // The edge that leaves PAUSE counts like a RUN edge, so a pause of L cycles costs exactly L cycles.
    assign count_edge = ((cur == RUN) || (cur == PAUSE)) && !stop && !pause;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE: begin
                if (start && !stop) nxt = RUN;
            end
            RUN, PAUSE: begin
                if (stop)
                    nxt = IDLE;
                else if (pause)
                    nxt = PAUSE;
                else if (tick && at_term && !mode_l)
                    nxt = DONE;
                else
                    nxt = RUN;
            end
            DONE: begin
                if (stop)       nxt = IDLE;
                else if (start) nxt = RUN;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        q_nxt        = q;
        pre_cnt_nxt  = pre_cnt;
        done_nxt     = 1'b0;
        term_nxt     = term_l;
        mode_nxt     = mode_l;
        prescale_nxt = prescale_l;
        if (stop && (cur != IDLE)) begin
            q_nxt       = '0;
            pre_cnt_nxt = '0;
        end else if (load) begin
            term_nxt     = load_val;
            mode_nxt     = mode;
            prescale_nxt = prescale;
            q_nxt        = '0;
            pre_cnt_nxt  = '0;
        end else if (count_edge) begin
            if (tick) begin
                pre_cnt_nxt = '0;
                if (at_term) begin
                    done_nxt = 1'b1;
                    q_nxt    = mode_l ? '0 : q;
                end else begin
                    q_nxt = q + 1'b1;
                end
            end else begin
                pre_cnt_nxt = pre_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q          <= '0;
            pre_cnt    <= '0;
            done       <= 1'b0;
            term_l     <= '0;
            mode_l     <= 1'b0;
            prescale_l <= '0;
        end else begin
            q          <= q_nxt;
            pre_cnt    <= pre_cnt_nxt;
            done       <= done_nxt;
            term_l     <= term_nxt;
            mode_l     <= mode_nxt;
            prescale_l <= prescale_nxt;
        end
    end

    assign busy  = (cur == RUN) || (cur == PAUSE);
    assign state = cur;

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Control block that sequences a WIDTH-bit up-counter datapath as a programmable timer. It accepts start/stop/pause commands, latches a terminal count and run mode, divides the clock with a prescaler, and flags terminal count with a one-cycle pulse. It sits between software-facing control registers and the free-running counter, turning a bare counter into a one-shot or periodic timer.

## Interface
- WIDTH, 4, counter and terminal-count width
- PRE_W, 4, prescaler width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled in IDLE and DONE only
- stop  input  1  abort and return to IDLE; highest priority
- pause  input  1  level; freezes counter and prescaler while high in RUN
- mode  input  1  0 = one-shot, 1 = auto-reload; latched on start
- load_val  input  WIDTH  terminal count; latched on start
- prescale  input  PRE_W  tick every prescale+1 cycles; latched on start
- q  output  WIDTH  current count
- busy  output  1  high in RUN or PAUSE
- done  output  1  one-cycle pulse at terminal count
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

## Operation
- Reset (rst=0, asynchronous): state=IDLE, q=0, pre_cnt=0, done=0, busy=0; latched term/mode/prescale cleared to 0.
- Tick: in RUN with pause=0, pre_cnt increments; when pre_cnt==prescale_l, tick fires and pre_cnt clears to 0. prescale=0 → tick every cycle.
- IDLE: start → RUN; latch load_val→term, mode, prescale; q=0; pre_cnt=0. start and stop together → stay IDLE.
- RUN, per-edge priority stop > pause > tick:
  - stop → IDLE, q=0, pre_cnt=0, no done.
  - pause → PAUSE; q and pre_cnt hold; no tick this edge.
  - tick with q!=term → q=q+1.
  - tick with q==term → done pulse; mode=1: q=0, stay RUN; mode=0: q holds term, → DONE.
  - start ignored.
- PAUSE: stop → IDLE (q=0); pause=0 → RUN, counting resumes from held q and pre_cnt; else hold.
- DONE: q holds term; start → RUN with fresh latch (q=0); stop → IDLE (q=0); start+stop → IDLE.
- term=0: every tick is terminal; auto-reload gives done on every tick, q stays 0.
- Counter never wraps by overflow; terminal compare precedes increment, so q ≤ term always.
- Inputs changed during RUN/PAUSE have no effect until next start.

## Timing
- All outputs registered (busy decoded from state register, no input-to-output combinational path).
- start sampled at edge N → state=RUN, q=0 after N.
- prescale=P, term=T: q reaches k after edge N+k(P+1); terminal tick at edge N+(T+1)(P+1); done high for the cycle following that edge, exactly one cycle.
- Auto-reload period: (T+1)(P+1) cycles between done pulses.
- Pause of L cycles adds exactly L cycles to remaining time.
- stop at edge M → IDLE, q=0, busy=0 after M; no done generated even if terminal tick coincides.
- rst assertion mid-run clears everything immediately, independent of clk; first start sampled at first rising edge with rst=1.

## Test plan
- Reset: drive rst=0 mid-count (q=5, RUN) → q=0, state=00, busy=0, done=0 immediately, before next edge.
- One-shot: load_val=9, prescale=0, mode=0, start at edge N → q=1..9 on edges N+1..N+9, done high one cycle after edge N+10, state=11, q holds 9.
- Auto-reload with prescale: load_val=3, prescale=2, mode=1 → q increments every 3 cycles, done every 12 cycles, q returns to 0, busy stays 1.
- Pause: one-shot load_val=7, pause high 5 cycles at q=4 → state=10, q stays 4; done arrives exactly 5 cycles later than unpaused run.
- Priority: stop and pause together in RUN → IDLE, q=0; stop on terminal-tick edge → no done; start+stop in IDLE → stays IDLE.
- Edge values: load_val=0, mode=1, prescale=0 → done high every cycle, q=0; load_val=15, WIDTH=4 → q reaches 15, no overflow, done after 16 ticks.
